mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Synchronous, parametrised up/down counter with programmable modulus, parallel load, synchronous clear and wrap/saturate mode. It succeeds the ripple up counter used in the sequential-circuit library. All bits change on one clock edge, so there are no ripple glitches. A combinational terminal-count output lets several instances be cascaded into wider counters.

## Interface
- N, 4: counter width in bits.
- MOD, 16: count modulus; q ranges 0..MOD-1. Legal range 2 ≤ MOD ≤ 2^N; elaboration must fail for any other value.
- SATURATE, 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- clr  input  1  synchronous clear to 0; also clears ovf.
- load  input  1  synchronous parallel load of din.
- din  input  N  load value.
- en  input  1  count enable.
- up  input  1  direction: 1 = count up, 0 = count down.
- q  output  N  current count.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse after a wrap event.
- ovf  output  1  sticky boundary-overrun flag, registered.

## Operation
- Reset values while rst is high and after its release: q=0, wrap=0, ovf=0. Whenever rst is asserted, these values apply immediately, independent of clk. tc then follows its equation.
- Priority per rising edge: rst > clr > load > en. Only the highest-priority active action takes effect.
- clr: q←0, ovf←0, wrap←0.
- load: q←din if din ≤ MOD-1, else q←MOD-1 (clamped). wrap←0. ovf is unchanged.
- en=1 with up=1:
  - q<MOD-1: q←q+1.
  - q=MOD-1 and SATURATE=0: q←0 and wrap←1.
  - q=MOD-1 and SATURATE=1: q holds and ovf←1.
- en=1 with up=0:
  - q>0: q←q-1.
  - q=0 and SATURATE=0: q←MOD-1 and wrap←1.
  - q=0 and SATURATE=1: q holds and ovf←1.
- en=0 with no clr or load: q holds and wrap←0.
- wrap is high for exactly one cycle per wrap event. It is never set when SATURATE=1.
- ovf is set only in SATURATE=1. It stays high until clr or rst.
- tc = en & ((up & q==MOD-1) | (~up & q==0)). It is purely combinational and does not depend on clr or load.
- Arithmetic is done in N bits. Wrap to 0 or MOD-1 is explicit, so it is correct for non-power-of-two MOD. No value ≥ MOD is ever reachable on q.
- Changing direction mid-count takes effect on the next edge, with no extra latency.

## Timing
- q, wrap and ovf are registered: latency is 1 cycle from the qualifying edge.
- tc has 0-cycle latency from q, en and up. Cascade rule: connect tc of the lower stage to en of the upper stage; both stages share clk.
- rst assertion takes effect asynchronously. After deassertion, the first action occurs on the first rising edge on which rst is low.
- rst deasserted and en high on the same edge: that edge counts normally.
- rst asserted mid-count or mid-pulse: q, wrap and ovf clear immediately. A pending wrap pulse is lost.
- clr and load asserted on the same edge: clr wins, so q=0.

## Test plan
- Reset: with N=4, MOD=10, assert rst mid-count at q=7 → q=0, wrap=0, ovf=0 without waiting for a clk edge. Release rst with en=1, up=1 → q=1 after the first edge.
- Up-wrap: N=4, MOD=10, SATURATE=0, en=1, up=1 from q=0 → 0..9, then 0. tc=1 only while q=9. wrap=1 for the single cycle in which q=0 after the wrap.
- Down-wrap and direction change: start at q=2, up=0 → q=1, 0, 9. Set up=1 at q=9 → q=0 next edge with wrap=1.
- Saturate: SATURATE=1, MOD=10, counting up → q holds at 9, ovf=1, wrap stays 0. clr → q=0, ovf=0. Counting down from 0 → q=0, ovf=1.
- Load and priority: din=5, load=1, en=1 → q=5. din=12 with MOD=10 → q=9. clr=1 and load=1 together → q=0. en=0 → q holds.
- Cascade: two N=4, MOD=10 instances, low tc driving high en, 25 enables → {high,low}={2,5}. High stage increments only on edges where low goes 9→0.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Synchronous up/down counter with programmable modulus, parallel load, clear
// and wrap/saturate boundary behaviour; tc is combinational for cascading.
module mod_updown_counter #(
  parameter int N        = 4,
  parameter int MOD      = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         en,
  input  logic         up,
  output logic [N-1:0] q,
  output logic         tc,
  output logic         wrap,
  output logic         ovf
);

  if ((MOD < 2) || (longint'(MOD) > (longint'(1) << N))) begin : g_bad_mod
    $error("mod_updown_counter: MOD must satisfy 2 <= MOD <= 2**N");
  end

  localparam logic [N-1:0] MAXV = N'(MOD - 1);
  localparam logic [N-1:0] ONE  = N'(1);

  logic atMax;
  logic atZero;

  assign atMax  = (q == MAXV);
  assign atZero = (q == '0);
  assign tc     = en & ((up & atMax) | (~up & atZero));

  // Boundaries are handled explicitly so a non-power-of-two MOD never reaches q >= MOD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      q    <= (din > MAXV) ? MAXV : din;
      wrap <= 1'b0;
    end else if (en) begin
      wrap <= 1'b0;
      if (up) begin
        if (!atMax) begin
          q <= q + ONE;
        end else if (SATURATE) begin
          ovf <= 1'b1;
        end else begin
          q    <= '0;
          wrap <= 1'b1;
        end
      end else begin
        if (!atZero) begin
          q <= q - ONE;
        end else if (SATURATE) begin
          ovf <= 1'b1;
        end else begin
          q    <= MAXV;
          wrap <= 1'b1;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: wrap, saturate and power-of-two instances share stimulus,
// plus a two-stage decade cascade; an arithmetic model is compared every cycle.
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic load = 1'b0;
  logic [3:0] din = 4'd0;
  logic en = 1'b0;
  logic up = 1'b1;
  logic casEn = 1'b0;

  logic [3:0] qv [5];
  logic tcv [5];
  logic wv [5];
  logic ov [5];

  int mq [5];
  bit mw [5];
  bit mo [5];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // 0: MOD=10 wrap, 1: MOD=10 saturate, 2: MOD=16 wrap, 3/4: cascade low/high
  mod_updown_counter #(.N(4), .MOD(10), .SATURATE(1'b0)) dutWrap (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(qv[0]), .tc(tcv[0]), .wrap(wv[0]), .ovf(ov[0]));

  mod_updown_counter #(.N(4), .MOD(10), .SATURATE(1'b1)) dutSat (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(qv[1]), .tc(tcv[1]), .wrap(wv[1]), .ovf(ov[1]));

  mod_updown_counter #(.N(4)) dutPow2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .up(up),
    .q(qv[2]), .tc(tcv[2]), .wrap(wv[2]), .ovf(ov[2]));

  mod_updown_counter #(.N(4), .MOD(10), .SATURATE(1'b0)) dutLow (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .din(4'd0), .en(casEn), .up(1'b1),
    .q(qv[3]), .tc(tcv[3]), .wrap(wv[3]), .ovf(ov[3]));

  mod_updown_counter #(.N(4), .MOD(10), .SATURATE(1'b0)) dutHigh (
    .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .din(4'd0), .en(tcv[3]), .up(1'b1),
    .q(qv[4]), .tc(tcv[4]), .wrap(wv[4]), .ovf(ov[4]));

  // Next state from the counting rules in plain integer arithmetic; returns {q, wrap, ovf}.
  function automatic logic [33:0] stepModel(input int modv, input bit sat, input int qi,
                                             input bit oi, input bit c, input bit l,
                                             input int d, input bit e, input bit u);
    int nq;
    bit nw;
    bit no;
    nq = qi;
    nw = 1'b0;
    no = oi;
    if (c) begin
      nq = 0;
      no = 1'b0;
    end else if (l) begin
      nq = (d < modv) ? d : modv - 1;
    end else if (e) begin
      if (u) begin
        if (qi + 1 < modv) nq = qi + 1;
        else if (sat) no = 1'b1;
        else begin
          nq = 0;
          nw = 1'b1;
        end
      end else begin
        if (qi - 1 >= 0) nq = qi - 1;
        else if (sat) no = 1'b1;
        else begin
          nq = modv - 1;
          nw = 1'b1;
        end
      end
    end
    return {nq, nw, no};
  endfunction

  function automatic bit modelTc(input int i);
    int modv;
    bit e;
    bit u;
    modv = (i == 2) ? 16 : 10;
    if (i < 3) begin
      e = en;
      u = up;
    end else begin
      u = 1'b1;
      e = (i == 3) ? casEn : (casEn && mq[3] == 9);
    end
    return e && ((u && mq[i] == modv - 1) || (!u && mq[i] == 0));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        mq[i] <= 0;
        mw[i] <= 1'b0;
        mo[i] <= 1'b0;
      end
    end else begin
      {mq[0], mw[0], mo[0]} <= stepModel(10, 1'b0, mq[0], mo[0], clr, load, int'(din), en, up);
      {mq[1], mw[1], mo[1]} <= stepModel(10, 1'b1, mq[1], mo[1], clr, load, int'(din), en, up);
      {mq[2], mw[2], mo[2]} <= stepModel(16, 1'b0, mq[2], mo[2], clr, load, int'(din), en, up);
      {mq[3], mw[3], mo[3]} <= stepModel(10, 1'b0, mq[3], mo[3], 1'b0, 1'b0, 0, casEn, 1'b1);
      {mq[4], mw[4], mo[4]} <= stepModel(10, 1'b0, mq[4], mo[4], 1'b0, 1'b0, 0,
                                         casEn && (mq[3] == 9), 1'b1);
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("dut%0d q", i), int'(qv[i]), mq[i]);
      checkOutput($sformatf("dut%0d wrap", i), int'(wv[i]), int'(mw[i]));
      checkOutput($sformatf("dut%0d ovf", i), int'(ov[i]), int'(mo[i]));
      checkOutput($sformatf("dut%0d tc", i), int'(tcv[i]), int'(modelTc(i)));
    end
  end

  task automatic applyStimulus(input bit c, input bit l, input logic [3:0] d,
                               input bit e, input bit u);
    clr  = c;
    load = l;
    din  = d;
    en   = e;
    up   = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1'b1;
    up = 1'b1;
    #3;
    checkOutput("reset q", int'(qv[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("first edge after release", int'(qv[0]), 1);

    repeat (6) applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    checkOutput("count to 7", int'(qv[0]), 7);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset q", int'(qv[0]), 0);
    checkOutput("async reset pow2 q", int'(qv[2]), 0);
    checkOutput("async reset wrap", int'(wv[0]), 0);
    checkOutput("async reset ovf", int'(ov[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release with en counts", int'(qv[0]), 1);

    repeat (8) applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    checkOutput("up reaches 9", int'(qv[0]), 9);
    checkOutput("tc at 9 up", int'(tcv[0]), 1);
    checkOutput("pow2 tc at 9", int'(tcv[2]), 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    checkOutput("up wrap q", int'(qv[0]), 0);
    checkOutput("up wrap pulse", int'(wv[0]), 1);
    checkOutput("sat holds 9", int'(qv[1]), 9);
    checkOutput("sat ovf", int'(ov[1]), 1);
    checkOutput("sat no wrap", int'(wv[1]), 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    checkOutput("wrap one cycle", int'(wv[0]), 0);

    applyStimulus(1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
    checkOutput("load beats en", int'(qv[0]), 2);
    checkOutput("load keeps ovf", int'(ov[1]), 1);
    repeat (2) applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("down to 0", int'(qv[0]), 0);
    checkOutput("tc at 0 down", int'(tcv[0]), 1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("down wrap q", int'(qv[0]), 9);
    checkOutput("down wrap pulse", int'(wv[0]), 1);
    checkOutput("pow2 down wrap q", int'(qv[2]), 15);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    checkOutput("direction change q", int'(qv[0]), 0);
    checkOutput("direction change wrap", int'(wv[0]), 1);

    applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    checkOutput("clr clears ovf", int'(ov[1]), 0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    checkOutput("sat down holds 0", int'(qv[1]), 0);
    checkOutput("sat down ovf", int'(ov[1]), 1);

    applyStimulus(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    checkOutput("load 5", int'(qv[0]), 5);
    applyStimulus(1'b0, 1'b1, 4'd12, 1'b1, 1'b1);
    checkOutput("load clamp", int'(qv[0]), 9);
    checkOutput("pow2 load 12", int'(qv[2]), 12);
    applyStimulus(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    checkOutput("clr beats load", int'(qv[0]), 0);
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    repeat (2) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("en low holds", int'(qv[0]), 5);

    casEn = 1'b1;
    repeat (25) applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    checkOutput("cascade low", int'(qv[3]), 5);
    checkOutput("cascade high", int'(qv[4]), 2);
    casEn = 1'b0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
